// File: rtl/muldiv_sequencer.sv
// Sequential multiply/divide unit for the HI/LO register file: one result bit per cycle,
// with signed operands handled by magnitude arithmetic and a final sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             hi_w,
  output logic             lo_w,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t               state_r, next_state_s;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r, mag_r;
  logic [2*WIDTH-1:0]   acc_r, calc_next_s;
  logic [CW-1:0]        cnt_r;
  logic                 neg_lo_r, neg_hi_r, dz_pend_r;
  logic                 busy_r, done_r, dz_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  logic                 is_div_s, sa_s, sb_s;
  logic [WIDTH-1:0]     a_abs_s, b_abs_s, fix_hi_s, fix_lo_s;
  logic [WIDTH:0]       mul_sum_s, rem_sh_s, diff_s;
  logic [2*WIDTH-1:0]   prod_neg_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush returns any active state to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !flush) next_state_s = PREP;
        else                 next_state_s = IDLE;
      end
      PREP: begin
        if (flush) next_state_s = IDLE;
        else       next_state_s = CALC;
      end
      CALC: begin
        if (flush)                  next_state_s = IDLE;
        else if (cnt_r == CNT_LAST) next_state_s = FIX;
        else                        next_state_s = CALC;
      end
      FIX: begin
        if (flush) next_state_s = IDLE;
        else       next_state_s = DONE;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand magnitudes and one iteration of shift-add multiply / restoring divide
  always_comb begin
    is_div_s  = op_r[1];
    sa_s      = ~op_r[0] & a_r[WIDTH-1];
    sb_s      = ~op_r[0] & b_r[WIDTH-1];
    a_abs_s   = sa_s ? -a_r : a_r;
    b_abs_s   = sb_s ? -b_r : b_r;
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    rem_sh_s = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_sh_s - {1'b0, mag_r};
    if (!is_div_s) begin
      calc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (!diff_s[WIDTH]) begin
      calc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      calc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up; a zero divisor bypasses the iteration result entirely
  always_comb begin
    prod_neg_s = -acc_r;
    if (!is_div_s) begin
      if (neg_lo_r) begin
        fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_neg_s[WIDTH-1:0];
      end else begin
        fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
        fix_lo_s = acc_r[WIDTH-1:0];
      end
    end else if (dz_pend_r) begin
      fix_hi_s = a_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    end
  end

  // Datapath registers and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 2'b00;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      mag_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_lo_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      dz_pend_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      dz_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        PREP: begin
          cnt_r     <= CNT_INIT;
          neg_lo_r  <= sa_s ^ sb_s;
          neg_hi_r  <= sa_s;
          dz_pend_r <= is_div_s && (b_r == {WIDTH{1'b0}});
          if (is_div_s) begin
            mag_r <= b_abs_s;
            acc_r <= {{WIDTH{1'b0}}, a_abs_s};
          end else begin
            mag_r <= a_abs_s;
            acc_r <= {{WIDTH{1'b0}}, b_abs_s};
          end
        end
        CALC: begin
          acc_r <= calc_next_s;
          cnt_r <= cnt_r - CNT_LAST;
        end
        FIX: begin
          if (!flush) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
            dz_r <= dz_pend_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi_w = done_r;
  assign lo_w = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
  assign dz   = dz_r;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all values below are for WIDTH=32.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  WIDTH  rs operand (multiplicand/dividend).
REQ-007 b  input  WIDTH  rt operand (multiplier/divisor).
REQ-008 flush  input  1  synchronous abort from exception logic.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 hi_w  output  1  HI write strobe to the HI/LO register file.
REQ-012 lo_w  output  1  LO write strobe to the HI/LO register file.
REQ-013 hi  output  WIDTH  product high half / remainder.
REQ-014 lo  output  WIDTH  product low half / quotient.
REQ-015 dz  output  1  divide-by-zero flag for the last completed op.

Function
REQ-016 The FSM has five states: IDLE, PREP, CALC, FIX, DONE.
REQ-017 IDLE -> PREP on start=1 and flush=0 (the accept edge); op, a and b are latched at that edge and later input changes are ignored.
REQ-018 PREP lasts one cycle: for MULT/DIV, take absolute values of the operands and record the result signs (product: sign(a)^sign(b); quotient: sign(a)^sign(b); remainder: sign(a)); load the iteration counter with WIDTH.
REQ-019 CALC lasts exactly WIDTH cycles at one bit per cycle: shift-add multiply into a 2*WIDTH accumulator, or restoring divide; the counter decrements each cycle, and CALC -> FIX when the counter reaches 1.
REQ-020 FIX lasts one cycle: apply two's-complement negation per the recorded signs; then FIX -> DONE.
REQ-021 DONE lasts one cycle: done=hi_w=lo_w=1, hi/lo registers are updated, and dz is updated; then DONE -> IDLE.
REQ-022 Latency: done is high in the cycle that begins WIDTH+3 rising edges after the accept edge (35 for WIDTH=32); back-to-back ops accept no earlier than the first IDLE cycle after DONE.
REQ-023 Multiply: {hi,lo} = full 2*WIDTH product, signed for MULT and unsigned for MULTU.
REQ-024 Divide: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend for DIV.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0, dz=0, with no trap.
REQ-026 Divisor 0 (DIV or DIVU): the op runs with full normal latency; lo=all ones, hi=original dividend a, dz=1.
REQ-027 For multiply ops, dz=0.
REQ-028 A start while busy=1 is ignored, with no queuing and no error.
REQ-029 flush=1 in any non-IDLE state forces IDLE at the next edge; no done/hi_w/lo_w is produced, and hi, lo and dz keep their previous values.
REQ-030 flush=1 in IDLE blocks a simultaneous start.
REQ-031 hi/lo/dz hold their values between completions; done, hi_w and lo_w are never high outside DONE.

Reset
REQ-032 While rst=1 (asynchronous): state=IDLE, busy=done=hi_w=lo_w=dz=0, hi=lo=0, and all internal registers are cleared.
REQ-033 rst asserted mid-operation aborts it immediately with no write strobe; the first accept is possible on the first edge after rst deasserts.

Verification
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done/hi_w/lo_w 35 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001, busy high for 35 cycles.
REQ-035 MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIVU a=7 b=2 -> lo=3, hi=1.
REQ-036 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
REQ-037 DIVU a=5 b=0 -> after 35 cycles dz=1, lo=0xFFFFFFFF, hi=5; a following MULTU 2*3 -> dz=0, hi=0, lo=6.
REQ-038 Start DIVU, then assert start with new operands at CALC cycle 5 and flush at CALC cycle 10 -> the second start is ignored, busy drops after the flush edge, and there is no done/hi_w; hi/lo keep their previous results.
REQ-039 Assert rst at CALC cycle 20 of MULT -> outputs 0 immediately; after release, a new MULTU 4*4 completes with lo=16 after 35 cycles.
